// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-wait-state memory responder for the multi-cycle core
//
// Purpose: holds the unified instruction/data word array and serves one read or
// write per transaction. After acceptance it waits WAIT_CYCLES cycles and then
// issues a single-cycle response pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  core presents a request
//   req_ready  responder can accept (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  read data, held between responses
//   rsp_err    qualifies rsp_valid: address was out of range
//   busy       transaction in flight
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    valid_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    from_idle;
    logic                    commit;
    logic                    c_we;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic                    c_in_range;
    logic                    mem_we;

    // With zero wait states the acceptance edge is also the commit edge, so the
    // commit takes its operands straight from the request inputs in that case.
    assign from_idle  = (state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0);
    assign commit     = from_idle || ((state_q == S_WAIT) && (cnt_q == CW'(1)));
    assign c_we       = (state_q == S_IDLE) ? req_we    : we_q;
    assign c_addr     = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign c_wdata    = (state_q == S_IDLE) ? req_wdata : wdata_q;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    assign c_in_range = ({1'b0, c_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    // An asserted reset abandons the transaction, including its array write.
    assign mem_we     = commit && c_we && c_in_range && !reset;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = valid_q;
    assign rsp_err    = err_q;
    assign rsp_rdata  = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (commit) begin
                valid_q <= 1'b1;
                err_q   <= !c_in_range;
                rdata_q <= (c_in_range && !c_we) ? mem[c_addr] : '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CW'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_addr] <= c_wdata;
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle core's control FSM. Accepts one read or write request per transaction from the core's memory access states, models a fixed-wait-state synchronous memory, and returns a single-cycle response pulse.
- Holds the unified instruction/data word array.
- `busy` lets the control FSM hold its memory state until the response arrives.

Parameters:
- ADDR_WIDTH, 8, word address width.
- DATA_WIDTH, 16, word width.
- DEPTH, 256, number of implemented words (1..2^ADDR_WIDTH); higher addresses are out of range.
- WAIT_CYCLES, 2, wait states inserted between acceptance and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_WIDTH  read data; held between responses.
- rsp_err  output  1  qualifies rsp_valid: address was out of range.
- busy  output  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (async, active-high) and its effect on outputs and state:
  - state = IDLE, wait counter = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - req_ready = 1 after reset deasserts; busy = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid = 1 the request is accepted: latch req_we, req_addr, req_wdata; load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
  - Request inputs are ignored outside IDLE and need not be held after acceptance.
- WAIT:
  - req_ready = 0, busy = 1.
  - Counter decrements each cycle; when it reaches 1, next state is RESP.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- Commit edge (the edge entering RESP):
  - In-range write: array[addr] <= wdata; rsp_rdata <= 0.
  - In-range read: rsp_rdata <= array[addr].
  - Out of range (addr >= DEPTH): no array write; rsp_rdata <= 0; rsp_err <= 1.
- RESP:
  - rsp_valid = 1 for exactly one cycle, together with rsp_err; busy = 1; req_ready = 0.
  - Next state is IDLE unconditionally. There is no response backpressure.
- Latency and throughput:
  - rsp_valid is high in the cycle WAIT_CYCLES+1 cycles after the acceptance edge.
  - A new request can be accepted at the earliest on the edge ending the first IDLE cycle after RESP, so one transaction per WAIT_CYCLES+2 cycles.
- Ordering: strict. A read after a write to the same address returns the written data, because the write commits before the read is accepted.
- rsp_rdata and rsp_err hold their last response values until the next commit edge. rsp_err clears on the next commit edge if the next address is in range.
- Reset mid-transaction: the transaction is abandoned. If reset asserts before the commit edge, no array write occurs and no rsp_valid is produced.
- Counter width: max(1, clog2(WAIT_CYCLES+1)) bits. The counter never wraps.
- Simultaneous events: req_valid asserted during WAIT/RESP is neither queued nor accepted. The core must re-present it while req_ready = 1.

Test Plan:
- Reset, then idle: outputs are ready=1, busy=0, valid=0, err=0, rdata=0; no response for 10 cycles with req_valid = 0.
- WAIT_CYCLES=2: write addr 0x10 data 0xBEEF, then read 0x10.
  - Each rsp_valid arrives exactly 3 cycles after its acceptance edge; write rdata = 0.
  - The read returns 0xBEEF; each transaction spans 4 cycles.
- DEPTH=200: write 0x1234 to addr 0xC8, then read 0xC8.
  - Both responses have rsp_err = 1 and rdata = 0.
  - A read of addr 0xC7 afterwards returns its prior contents, unchanged.
- WAIT_CYCLES=0: back-to-back reads of 0x01 and 0x02, req_valid held high.
  - Responses in consecutive-transaction pattern: accept, RESP, IDLE, accept.
  - Data matches the preloaded values.
- Reset mid-transaction: write 0x5555 to addr 0x20 (WAIT_CYCLES=3), assert reset during the 2nd WAIT cycle.
  - No rsp_valid; a later read of 0x20 returns the old value.
- req_valid toggled during WAIT: the extra request is ignored, only one rsp_valid is produced, and busy stays high until RESP ends.
